// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - multiplexed seven-segment scan driver with frame-synchronous double buffering
module seg7_scan #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    output logic [3:0]            hex,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame,
    output logic                  ready
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

    logic [PW-1:0]         pcnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   active;
    logic [4*DIGITS-1:0]   pending;
    logic                  pend_v;
    logic                  tick;
    logic                  wrap;
    logic [DIGITS-1:0]     lz;
    logic                  blank;

    assign tick = (pcnt == PMAX);
    assign wrap = tick && (idx == IMAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt    <= '0;
            idx     <= '0;
            active  <= '0;
            pending <= '0;
            pend_v  <= 1'b0;
            frame   <= 1'b0;
        end else begin
            if (tick) begin
                pcnt <= '0;
                idx  <= (idx == IMAX) ? '0 : idx + 1'b1;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
            frame <= wrap;
            if (wrap && pend_v) begin
                active <= pending;
                pend_v <= 1'b0;
            end
            // A load on the wrap edge still lands in pending after the transfer above.
            if (load) begin
                pending <= value;
                pend_v  <= 1'b1;
            end
        end
    end

    // lz[i] is set when digits DIGITS-1 down to i of the active value are all zero.
    always_comb begin
        lz = '0;
        lz[DIGITS-1] = (active[4*(DIGITS-1) +: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            lz[i] = lz[i+1] && (active[4*i +: 4] == 4'h0);
        end
    end

    assign blank    = blank_lz && (idx != '0) && lz[idx];
    assign hex      = blank ? 4'hF : active[{idx, 2'b00} +: 4];
    assign digit_en = DIGITS'(1) << idx;
    assign ready    = ~pend_v;

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - directed self-checking bench for seg7_scan (DIGITS=4, SCAN_DIV=4)
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic [3:0]  hex;
    logic [3:0]  digit_en;
    logic        frame;
    logic        ready;

    int n_cmp = 0;
    int n_err = 0;

    seg7_scan #(.DIGITS(4), .SCAN_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .blank_lz (blank_lz),
        .hex      (hex),
        .digit_en (digit_en),
        .frame    (frame),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_val(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    // Advance to the next cycle with frame high; optionally require ready low while waiting.
    task automatic wait_frame(input string tag, input bit chk_busy);
        int n;
        n = 0;
        step();
        while (frame !== 1'b1 && n < 40) begin
            if (chk_busy) chk({tag, "_busy"}, ready, 1'b0);
            step();
            n++;
        end
        chk({tag, "_frame_seen"}, frame, 1'b1);
    endtask

    // Starting in a frame cycle, check all 16 cycles of one frame; exp holds the slot codes.
    task automatic show_frame(input string tag, input logic [15:0] exp, input logic exp_rdy);
        logic [3:0] eh;
        logic [3:0] een;
        chk({tag, "_rdy"}, ready, exp_rdy);
        for (int k = 0; k < 16; k++) begin
            eh  = exp[4*(k/4) +: 4];
            een = 4'b0001;
            een = een << (k / 4);
            chk({tag, "_hex"}, hex, eh);
            chk({tag, "_en"}, digit_en, een);
            chk({tag, "_frame"}, frame, (k == 0));
            step();
        end
        chk({tag, "_next_frame"}, frame, 1'b1);
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = 16'h9999;
        blank_lz = 1'b0;

        // Reset hold with load pulsing
        for (int i = 0; i < 10; i++) begin
            load = i[0];
            step();
            chk("rst_en", digit_en, 4'b0001);
            chk("rst_hex", hex, 4'h0);
            chk("rst_rdy", ready, 1'b1);
            chk("rst_frame", frame, 1'b0);
        end
        rst_n = 1'b1;
        load  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rel_en_hold", digit_en, 4'b0001);
            chk("rel_frame", frame, 1'b0);
        end
        step();
        chk("rel_en_adv", digit_en, 4'b0010);

        // Basic scan
        load_val(16'h1234);
        chk("basic_rdy_fall", ready, 1'b0);
        wait_frame("basic_wait", 1'b1);
        show_frame("basic", 16'h1234, 1'b1);
        show_frame("basic2", 16'h1234, 1'b1);

        // Leading-zero blanking
        blank_lz = 1'b1;
        load_val(16'h0050);
        wait_frame("lz50_wait", 1'b1);
        show_frame("lz50", 16'hFF50, 1'b1);
        load_val(16'h0000);
        wait_frame("lz00_wait", 1'b1);
        show_frame("lz00", 16'hFFF0, 1'b1);
        load_val(16'h0A00);
        wait_frame("lzA_wait", 1'b1);
        show_frame("lzA", 16'hFA00, 1'b1);
        for (int i = 0; i < 12; i++) step();
        chk("lz_drop_before", hex, 4'hF);
        blank_lz = 1'b0;
        step();
        chk("lz_drop_after", hex, 4'h0);
        chk("lz_drop_en", digit_en, 4'b1000);
        for (int i = 0; i < 3; i++) step();
        chk("lz_drop_frame", frame, 1'b1);

        // Load on the wrap edge
        load_val(16'h1111);
        wait_frame("w1_wait", 1'b1);
        for (int i = 0; i < 15; i++) step();
        chk("w_pre_en", digit_en, 4'b1000);
        load_val(16'h2222);
        chk("w_edge_frame", frame, 1'b1);
        show_frame("w1", 16'h1111, 1'b0);
        show_frame("w2", 16'h2222, 1'b1);

        // Double load within one frame
        load_val(16'h3333);
        load_val(16'h4444);
        wait_frame("dbl_wait", 1'b1);
        show_frame("dbl", 16'h4444, 1'b1);

        // Reset mid-operation
        load_val(16'h5678);
        wait_frame("mid_wait", 1'b1);
        load_val(16'h9999);
        for (int i = 0; i < 7; i++) step();
        chk("mid_pre_hex", hex, 4'h6);
        chk("mid_pre_en", digit_en, 4'b0100);
        chk("mid_pre_rdy", ready, 1'b0);
        rst_n = 1'b0;
        step();
        chk("mid_rst_en", digit_en, 4'b0001);
        chk("mid_rst_hex", hex, 4'h0);
        chk("mid_rst_rdy", ready, 1'b1);
        chk("mid_rst_frame", frame, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            chk("mid_after_hex", hex, 4'h0);
            chk("mid_after_rdy", ready, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
